// File: rtl/tt_pkg.sv
// Shared types and helpers for the truth-table sweeper.
// Contents: FSM state encoding, settle-counter width, first-set-bit encoder.
// Used by: tt_vec_counter, truth_table_sweeper.
package tt_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  // Wide enough for SETTLE up to 15 (counter runs 0..SETTLE-1).
  localparam int SETTLE_W = 4;

  // Index of the lowest set bit; 0 when no bit is set.
  function automatic logic [5:0] first_set(input logic [63:0] v);
    logic [5:0] r;
    r = 6'd0;
    for (int i = 63; i >= 0; i--) begin
      if (v[i]) r = 6'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/tt_vec_counter.sv
// Vector counter plus settle sub-counter for the truth-table sweeper.
// Ports: clk/rst; vec_clr/vec_inc drive vec, last = (vec == TW-1);
//        cnt_clr/cnt_inc drive cnt, cnt_last = (cnt == SETTLE-1).
module tt_vec_counter
  import tt_pkg::*;
#(
  parameter int N      = 3,
  parameter int SETTLE = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                vec_clr,
  input  logic                vec_inc,
  input  logic                cnt_clr,
  input  logic                cnt_inc,
  output logic [N-1:0]        vec,
  output logic                last,
  output logic [SETTLE_W-1:0] cnt,
  output logic                cnt_last
);

  // TW-1 is all ones in N bits, so the last vector is a simple AND-reduce.
  assign last     = &vec;
  assign cnt_last = (cnt == SETTLE_W'(SETTLE - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      vec <= '0;
      cnt <= '0;
    end else begin
      if (vec_clr)              vec <= '0;
      else if (vec_inc && !last) vec <= vec + 1'b1;

      if (cnt_clr)      cnt <= '0;
      else if (cnt_inc) cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/truth_table_sweeper.sv
// Sweeps a combinational function through all 2**N inputs, captures its truth table and checks it.
// Ports: clk, rst (sync, active-high), start, f_in, expected[TW] in;
//        vec[N], busy, done, table_out[TW], ones_count[N+1], match, first_err[N] out.
module truth_table_sweeper
  import tt_pkg::*;
#(
  parameter  int N      = 3,
  parameter  int SETTLE = 1,
  localparam int TW     = 1 << N
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          f_in,
  input  logic [TW-1:0] expected,
  output logic [N-1:0]  vec,
  output logic          busy,
  output logic          done,
  output logic [TW-1:0] table_out,
  output logic [N:0]    ones_count,
  output logic          match,
  output logic [N-1:0]  first_err
);

  localparam int CW = N + 1;

  state_t               state, state_nxt;
  logic [TW-1:0]        exp_q;
  logic [TW-1:0]        tbl_nxt;
  logic                 last, cnt_last;
  logic [SETTLE_W-1:0]  cnt;
  logic                 vec_clr, vec_inc, cnt_clr, cnt_inc;
  logic                 load, sample;

  tt_vec_counter #(.N(N), .SETTLE(SETTLE)) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .vec_clr  (vec_clr),
    .vec_inc  (vec_inc),
    .cnt_clr  (cnt_clr),
    .cnt_inc  (cnt_inc),
    .vec      (vec),
    .last     (last),
    .cnt      (cnt),
    .cnt_last (cnt_last)
  );

  assign busy = (state == ST_SETTLE) || (state == ST_SAMPLE);
  assign done = (state == ST_DONE);

  // Table including the bit being sampled this cycle, so the DONE-entry
  // compare sees the complete table.
  always_comb begin
    tbl_nxt      = table_out;
    tbl_nxt[vec] = f_in;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    vec_clr   = 1'b0;
    vec_inc   = 1'b0;
    cnt_clr   = 1'b0;
    cnt_inc   = 1'b0;
    load      = 1'b0;
    sample    = 1'b0;
    unique case (state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          load      = 1'b1;
          vec_clr   = 1'b1;
          cnt_clr   = 1'b1;
          state_nxt = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (cnt_last) state_nxt = ST_SAMPLE;
        else          cnt_inc   = 1'b1;
      end
      ST_SAMPLE: begin
        sample = 1'b1;
        if (last) begin
          state_nxt = ST_DONE;
        end else begin
          vec_inc   = 1'b1;
          cnt_clr   = 1'b1;
          state_nxt = ST_SETTLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      exp_q      <= '0;
      table_out  <= '0;
      ones_count <= '0;
      match      <= 1'b0;
      first_err  <= '0;
    end else if (load) begin
      exp_q      <= expected;
      table_out  <= '0;
      ones_count <= '0;
    end else if (sample) begin
      table_out  <= tbl_nxt;
      ones_count <= ones_count + CW'(f_in);
      if (last) begin
        match     <= (tbl_nxt == exp_q);
        first_err <= N'(first_set(64'(tbl_nxt ^ exp_q)));
      end
    end
  end

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Scoreboard bench for truth_table_sweeper: directed sweeps on a SETTLE=1 and a SETTLE=3 instance.
// Stimulus pushes expected results; monitors pop and compare on each rising done.
module tb_truth_table_sweeper;

  logic       clk = 1'b0;
  logic       rst, start, start3;
  logic [7:0] expected, expected3;
  logic [2:0] vec, vec3;
  logic       busy, done, busy3, done3, match, match3;
  logic [7:0] table_out, table3;
  logic [3:0] ones_count, ones3;
  logic [2:0] first_err, ferr3;
  logic       f_in, f3;
  logic       f_d1, f_d2, f3_d1;
  int         fmode;
  int         cyc = 0;
  int         passed = 0, total = 0;

  typedef struct {
    logic [7:0] tbl;
    logic [3:0] ones;
    logic       m;
    logic [2:0] fe;
    int         acc;
    int         lat;
  } exp_t;
  exp_t q1[$], q3[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic fx(input logic [2:0] v);
    return v[2] & ~v[1] & v[0];
  endfunction

  always @(posedge clk) begin
    f_d1  <= fx(vec);
    f_d2  <= f_d1;
    f3_d1 <= fx(vec3);
  end

  always_comb begin
    case (fmode)
      1:       f_in = 1'b1;
      3:       f_in = f_d2;
      default: f_in = fx(vec);
    endcase
  end
  assign f3 = f3_d1;

  truth_table_sweeper #(.N(3), .SETTLE(1)) dut (
    .clk(clk), .rst(rst), .start(start), .f_in(f_in), .expected(expected),
    .vec(vec), .busy(busy), .done(done), .table_out(table_out),
    .ones_count(ones_count), .match(match), .first_err(first_err)
  );

  truth_table_sweeper #(.N(3), .SETTLE(3)) dut3 (
    .clk(clk), .rst(rst), .start(start3), .f_in(f3), .expected(expected3),
    .vec(vec3), .busy(busy3), .done(done3), .table_out(table3),
    .ones_count(ones3), .match(match3), .first_err(ferr3)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
  endtask

  task automatic push1(input logic [7:0] t, input logic [3:0] o, input logic m,
                       input logic [2:0] fe, input int acc, input int lat);
    exp_t e;
    e.tbl = t; e.ones = o; e.m = m; e.fe = fe; e.acc = acc; e.lat = lat;
    q1.push_back(e);
  endtask

  // Monitors: compare results on each rising edge of done.
  logic done_d = 1'b0, done3_d = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (done && !done_d) begin
      if (q1.size() == 0) check("unexpected_done", 32'd1, 32'd0);
      else begin
        e = q1.pop_front();
        check("table_out", table_out, e.tbl);
        check("ones_count", ones_count, e.ones);
        check("match", match, e.m);
        check("first_err", first_err, e.fe);
        check("latency", cyc - e.acc, e.lat);
        check("table_known", !$isunknown(table_out), 1);
      end
    end
    done_d = done;
  end

  always @(negedge clk) begin
    exp_t e;
    if (done3 && !done3_d) begin
      if (q3.size() == 0) check("unexpected_done3", 32'd1, 32'd0);
      else begin
        e = q3.pop_front();
        check("table3", table3, e.tbl);
        check("ones3", ones3, e.ones);
        check("match3", match3, e.m);
        check("ferr3", ferr3, e.fe);
        check("latency3", cyc - e.acc, e.lat);
      end
    end
    done3_d = done3;
  end

  // Called at a negedge; returns at the negedge after the accept edge.
  task automatic start1(input logic [7:0] e, output int acc);
    start = 1'b1; expected = e; acc = cyc + 1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int bound);
    int i = 0;
    while (!done && i < bound) begin @(negedge clk); i++; end
    check("done_seen", done, 1);
  endtask

  int acc;

  initial begin
    rst = 1'b1; start = 1'b0; start3 = 1'b0; expected = '0; expected3 = '0; fmode = 0;
    repeat (2) @(negedge clk);
    check("rst_vec", vec, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_table", table_out, 0);
    check("rst_ones", ones_count, 0);
    check("rst_match", match, 0);
    check("rst_ferr", first_err, 0);
    check("rst_done3", done3, 0);
    rst = 1'b0;
    @(negedge clk);

    // 1: x&~y&z, matching expected; vec steps every 2 cycles.
    start1(8'h20, acc);
    push1(8'h20, 4'd1, 1'b1, 3'd0, acc, 16);
    for (int k = 1; k <= 16; k++) begin
      check("vec_step", vec, (k - 1) / 2);
      @(negedge clk);
    end
    wait_done(40);

    // 2: same function, wrong expected -> first diff at bit 4.
    start1(8'h30, acc);
    push1(8'h20, 4'd1, 1'b0, 3'd4, acc, 16);
    wait_done(40);

    // 3: f tied high, full-width popcount.
    fmode = 1;
    start1(8'hFF, acc);
    push1(8'hFF, 4'd8, 1'b1, 3'd0, acc, 16);
    wait_done(40);

    // 4: reset at cycle 7 of a sweep, with start also high (rst wins).
    fmode = 0;
    start1(8'h20, acc);
    repeat (6) @(negedge clk);
    check("pre_rst_vec", vec, 3);
    check("pre_rst_busy", busy, 1);
    rst = 1'b1; start = 1'b1; expected = 8'hFF;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    check("mid_rst_vec", vec, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_table", table_out, 0);
    check("mid_rst_ones", ones_count, 0);
    check("mid_rst_match", match, 0);
    @(negedge clk);
    start1(8'h20, acc);
    push1(8'h20, 4'd1, 1'b1, 3'd0, acc, 16);
    wait_done(40);

    // 5: start while busy ignored; start in DONE restarts.
    start1(8'h20, acc);
    push1(8'h20, 4'd1, 1'b1, 3'd0, acc, 16);
    repeat (4) @(negedge clk);
    start = 1'b1; expected = 8'hFF;
    @(negedge clk);
    start = 1'b0;
    wait_done(40);
    start1(8'h30, acc);
    check("restart_done", done, 0);
    check("restart_busy", busy, 1);
    check("restart_vec", vec, 0);
    push1(8'h20, 4'd1, 1'b0, 3'd4, acc, 16);
    wait_done(40);

    // 6a: SETTLE=3 tolerates a 1-cycle-delayed function.
    begin
      exp_t e;
      start3 = 1'b1; expected3 = 8'h20;
      e.tbl = 8'h20; e.ones = 4'd1; e.m = 1'b1; e.fe = 3'd0; e.acc = cyc + 1; e.lat = 32;
      q3.push_back(e);
      @(negedge clk);
      start3 = 1'b0;
      for (int i = 0; i < 60 && !done3; i++) @(negedge clk);
      check("done3_seen", done3, 1);
    end

    // 6b: SETTLE=1 with a 2-cycle-delayed function samples f(i-1): table shifts up by one.
    fmode = 3;
    start1(8'h20, acc);
    push1(8'h40, 4'd1, 1'b0, 3'd5, acc, 16);
    wait_done(40);

    repeat (3) @(negedge clk);
    check("q1_empty", q1.size(), 0);
    check("q3_empty", q3.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
